// File: rtl/mem_loader_pkg.sv
// Shared constants and types for the byte-stream memory loader.
// Optional feature macro: MEM_LOADER_CKSUM_EN (trailing XOR checksum byte per LOAD frame).
package mem_loader_pkg;

    localparam int unsigned ML_ADDR_W  = 11;
    localparam int unsigned WORD_BYTES = 4;

    localparam logic [7:0] CMD_LOAD_IMEM = 8'hA5;
    localparam logic [7:0] CMD_LOAD_DMEM = 8'hA6;
    localparam logic [7:0] CMD_RUN       = 8'h5A;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR0,
        S_ADDR1,
        S_CNT0,
        S_CNT1,
        S_DATA,
        S_CKSUM,
        S_ERROR
    } state_e;

    function automatic logic is_load_cmd(input logic [7:0] b);
        return (b == CMD_LOAD_IMEM) || (b == CMD_LOAD_DMEM);
    endfunction

endpackage

// File: rtl/mem_loader_byte_to_word.sv
// Assembles little-endian bytes into 32-bit words; flags the byte that completes a word.
module mem_loader_byte_to_word
    import mem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        word_valid_c,
    output logic [31:0] word_c
);

    logic [1:0]  idx_q, idx_d;
    // Only the first three bytes need storing; the fourth is taken straight from in_data.
    logic [23:0] sr_q, sr_d;

    // Byte index and LSB-first shift register update.
    always_comb begin
        idx_d        = idx_q;
        sr_d         = sr_q;
        word_valid_c = in_valid && (idx_q == 2'(WORD_BYTES - 1));
        word_c       = {in_data, sr_q};
        if (clear) begin
            idx_d = 2'd0;
        end else if (in_valid) begin
            idx_d = idx_q + 2'd1;
            sr_d  = {in_data, sr_q[23:8]};
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q <= 2'd0;
            sr_q  <= 24'd0;
        end else begin
            idx_q <= idx_d;
            sr_q  <= sr_d;
        end
    end

endmodule

// File: rtl/mem_loader.sv
// Boot loader: parses LOAD/RUN frames from a byte stream and drives imem/dmem write ports.
// Optional feature macro: MEM_LOADER_CKSUM_EN (XOR checksum byte closes each non-empty LOAD frame).
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = ML_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              mem_we,
    output logic              mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_reset,
    output logic              busy,
    output logic              err
);

    state_e            state_q, state_d;
    logic              rx_ready_q, rx_ready_d;
    logic              mem_we_q, mem_we_d;
    logic              mem_sel_q, mem_sel_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              core_reset_q, core_reset_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [7:0]        lo_q, lo_d;
`ifdef MEM_LOADER_CKSUM_EN
    logic [7:0]        cksum_q, cksum_d;
`endif

    logic        accept;
    logic        b2w_clear;
    logic        b2w_valid;
    logic        word_valid_c;
    logic [31:0] word_c;

    assign accept    = rx_valid && rx_ready_q;
    assign b2w_valid = accept && (state_q == S_DATA);

    mem_loader_byte_to_word u_b2w (
        .clk          (clk),
        .reset        (reset),
        .clear        (b2w_clear),
        .in_valid     (b2w_valid),
        .in_data      (rx_data),
        .word_valid_c (word_valid_c),
        .word_c       (word_c)
    );

    // Frame parser: next state, field capture and registered outputs.
    always_comb begin
        state_d      = state_q;
        rx_ready_d   = rx_ready_q;
        mem_we_d     = 1'b0;
        mem_sel_d    = mem_sel_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        core_reset_d = core_reset_q;
        busy_d       = busy_q;
        err_d        = err_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        lo_d         = lo_q;
        b2w_clear    = 1'b0;
`ifdef MEM_LOADER_CKSUM_EN
        cksum_d      = cksum_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_load_cmd(rx_data)) begin
                        mem_sel_d    = (rx_data == CMD_LOAD_DMEM);
                        core_reset_d = 1'b1;
                        busy_d       = 1'b1;
                        state_d      = S_ADDR0;
                    end else if (rx_data == CMD_RUN) begin
                        core_reset_d = 1'b0;
                    end else begin
                        state_d      = S_ERROR;
                        rx_ready_d   = 1'b0;
                        err_d        = 1'b1;
                        core_reset_d = 1'b1;
                        busy_d       = 1'b0;
                    end
                end
            end
            S_ADDR0: begin
                if (accept) begin
                    lo_d    = rx_data;
                    state_d = S_ADDR1;
                end
            end
            S_ADDR1: begin
                if (accept) begin
                    addr_d  = ADDR_W'({rx_data, lo_q});
                    state_d = S_CNT0;
                end
            end
            S_CNT0: begin
                if (accept) begin
                    lo_d    = rx_data;
                    state_d = S_CNT1;
                end
            end
            S_CNT1: begin
                if (accept) begin
                    if ({rx_data, lo_q} == 16'd0) begin
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d     = {rx_data, lo_q};
                        b2w_clear = 1'b1;
                        state_d   = S_DATA;
`ifdef MEM_LOADER_CKSUM_EN
                        cksum_d   = 8'd0;
`endif
                    end
                end
            end
            S_DATA: begin
`ifdef MEM_LOADER_CKSUM_EN
                if (accept) begin
                    cksum_d = cksum_q ^ rx_data;
                end
`endif
                if (word_valid_c) begin
                    mem_we_d    = 1'b1;
                    mem_wdata_d = word_c;
                    mem_addr_d  = addr_q;
                    addr_d      = addr_q + ADDR_W'(1);
                    cnt_d       = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) begin
`ifdef MEM_LOADER_CKSUM_EN
                        state_d = S_CKSUM;
`else
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
`endif
                    end
                end
            end
`ifdef MEM_LOADER_CKSUM_EN
            S_CKSUM: begin
                if (accept) begin
                    busy_d = 1'b0;
                    if (rx_data == cksum_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d      = S_ERROR;
                        rx_ready_d   = 1'b0;
                        err_d        = 1'b1;
                        core_reset_d = 1'b1;
                    end
                end
            end
`endif
            S_ERROR: begin
                rx_ready_d   = 1'b0;
                err_d        = 1'b1;
                core_reset_d = 1'b1;
                busy_d       = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rx_ready_q   <= 1'b1;
            mem_we_q     <= 1'b0;
            mem_sel_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'd0;
            core_reset_q <= 1'b1;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= '0;
            cnt_q        <= 16'd0;
            lo_q         <= 8'd0;
`ifdef MEM_LOADER_CKSUM_EN
            cksum_q      <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            rx_ready_q   <= rx_ready_d;
            mem_we_q     <= mem_we_d;
            mem_sel_q    <= mem_sel_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            core_reset_q <= core_reset_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            lo_q         <= lo_d;
`ifdef MEM_LOADER_CKSUM_EN
            cksum_q      <= cksum_d;
`endif
        end
    end

    assign rx_ready   = rx_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_sel    = mem_sel_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign core_reset = core_reset_q;
    assign busy       = busy_q;
    assign err        = err_q;

endmodule

// File: tb/tb_mem_loader.sv
// Scoreboard bench for mem_loader: frames are modelled as lists of expected word writes.
module tb_mem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        mem_we;
    logic        mem_sel;
    logic [10:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        core_reset;
    logic        busy;
    logic        err;

    int total = 0;
    int bad   = 0;
    bit gaps_en = 1'b0;

    typedef struct {
        logic        sel;
        logic [10:0] addr;
        logic [31:0] data;
        logic        busy;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] payload[$];

    mem_loader dut (
        .clk        (clk),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .mem_we     (mem_we),
        .mem_sel    (mem_sel),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .core_reset (core_reset),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every write strobe must match the head of the expected queue.
    always @(negedge clk) begin
        wr_t e;
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: actual sel=%0d addr=%h data=%h required no write",
                         mem_sel, mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                check("wr_sel", 32'(mem_sel), 32'(e.sel));
                check("wr_addr", 32'(mem_addr), 32'(e.addr));
                check("wr_data", mem_wdata, e.data);
`ifndef MEM_LOADER_CKSUM_EN
                check("wr_busy", 32'(busy), 32'(e.busy));
`endif
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b);
        if (gaps_en) begin
            repeat ($urandom_range(0, 2)) begin
                rx_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    // Reference model: word i of a frame goes to (addr + i) mod 2048, bytes little-endian.
    task automatic send_frame(input logic sel, input logic [15:0] addr, input int cnt, input bit bad_ck);
        logic [7:0] ck;
        wr_t        e;
        if (payload.size() != cnt * 4) begin
            payload.delete();
            for (int i = 0; i < cnt * 4; i++) payload.push_back(8'($urandom));
        end
        for (int i = 0; i < cnt; i++) begin
            e.sel  = sel;
            e.addr = 11'((int'(addr) + i) % 2048);
            e.data = {payload[4*i+3], payload[4*i+2], payload[4*i+1], payload[4*i]};
            e.busy = (i != cnt - 1);
            exp_q.push_back(e);
        end
        send_byte(sel ? 8'hA6 : 8'hA5);
        send_byte(addr[7:0]);
        send_byte(addr[15:8]);
        send_byte(8'(cnt));
        send_byte(8'(cnt >> 8));
        ck = 8'h00;
        foreach (payload[i]) begin
            send_byte(payload[i]);
            ck = ck ^ payload[i];
        end
`ifdef MEM_LOADER_CKSUM_EN
        if (cnt > 0) send_byte(bad_ck ? (ck ^ 8'h01) : ck);
`else
        if (bad_ck) ck = 8'h00;
`endif
        payload.delete();
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        check("drain", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic check_reset_vals();
        check("rst_rx_ready", 32'(rx_ready), 32'd1);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_sel", 32'(mem_sel), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_core_reset", 32'(core_reset), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals();
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        @(posedge clk);
        #1;
        do_reset();

        // Two-word imem frame.
        payload = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56, 8'h34, 8'h12};
        send_frame(1'b0, 16'h0010, 2, 1'b0);
        wait_drain();
        check("f1_core_reset", 32'(core_reset), 32'd1);
        check("f1_busy", 32'(busy), 32'd0);

        // dmem frame wrapping from the top address to zero.
        payload = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h11, 8'h11, 8'h11, 8'h11};
        send_frame(1'b1, 16'h07FF, 2, 1'b0);
        wait_drain();

        // RUN then an empty LOAD.
        @(negedge clk);
        check("pre_run_core_reset", 32'(core_reset), 32'd1);
        send_byte(8'h5A);
        check("run_core_reset", 32'(core_reset), 32'd0);
        check("run_busy", 32'(busy), 32'd0);
        send_byte(8'hA5);
        check("reload_core_reset", 32'(core_reset), 32'd1);
        check("reload_busy", 32'(busy), 32'd1);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        check("cnt1_busy_pre", 32'(busy), 32'd1);
        send_byte(8'h00);
        check("cnt0_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;

        // RUN bytes inside a frame are payload.
        payload = '{8'h5A, 8'h5A, 8'h5A, 8'h5A};
        send_frame(1'b0, 16'h0123, 1, 1'b0);
        wait_drain();
        check("run_as_data_core_reset", 32'(core_reset), 32'd1);

        // Random frames with random idle gaps; high address bits must be ignored.
        gaps_en = 1'b1;
        for (int f = 0; f < 24; f++) begin
            send_frame(1'($urandom), 16'($urandom), int'($urandom_range(0, 4)), 1'b0);
            wait_drain();
            check("rand_busy_idle", 32'(busy), 32'd0);
            check("rand_err", 32'(err), 32'd0);
        end
        gaps_en = 1'b0;

        // Reset mid-word discards the partial word.
        send_byte(8'h5A);
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hAA);
        send_byte(8'hBB);
        do_reset();
        repeat (3) @(posedge clk);
        #1;
        payload = '{8'h04, 8'h03, 8'h02, 8'h01};
        send_frame(1'b0, 16'h0000, 1, 1'b0);
        wait_drain();

        // Illegal command locks the loader in error.
        send_byte(8'h5A);
        check("err_pre_core_reset", 32'(core_reset), 32'd0);
        send_byte(8'h33);
        check("err_flag", 32'(err), 32'd1);
        check("err_rx_ready", 32'(rx_ready), 32'd0);
        check("err_core_reset", 32'(core_reset), 32'd1);
        check("err_busy", 32'(busy), 32'd0);
        begin
            logic [7:0] junk [9];
            junk = '{8'hA5, 8'h00, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
            foreach (junk[i]) send_byte(junk[i]);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("err_sticky", 32'(err), 32'd1);
        check("err_still_blocked", 32'(rx_ready), 32'd0);
        do_reset();

`ifdef MEM_LOADER_CKSUM_EN
        payload = '{8'h01, 8'h02, 8'h03, 8'h04};
        send_frame(1'b0, 16'h0000, 1, 1'b0);
        wait_drain();
        check("ck_good_err", 32'(err), 32'd0);
        check("ck_good_busy", 32'(busy), 32'd0);
        check("ck_good_ready", 32'(rx_ready), 32'd1);
        payload = '{8'h01, 8'h02, 8'h03, 8'h04};
        send_frame(1'b0, 16'h0000, 1, 1'b1);
        wait_drain();
        check("ck_bad_err", 32'(err), 32'd1);
        check("ck_bad_ready", 32'(rx_ready), 32'd0);
        do_reset();
`endif

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
